// File: rtl/pc_flow_sequencer.sv
// rtl/pc_flow_sequencer.sv - PC update sequencer: boot vector, fetch, branch, interrupt push/vector, RTI pop/return.
module pc_flow_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0020,
   parameter logic [31:0] INT_VECTOR   = 32'h0000_0000,
   parameter logic [31:0] PC_LIMIT     = 32'd1000,
   parameter int          FLUSH_CYCLES = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        int_req,
   input  logic        rti_req,
   input  logic        stall_in,
   input  logic        branch_taken,
   input  logic [31:0] branch_dst,
   input  logic [31:0] pc_cur,
   input  logic        mem_ack,
   input  logic [15:0] mem_rdata,
   output logic [1:0]  pc_sel,
   output logic [31:0] pc_load_val,
   output logic        flush,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_wdata,
   output logic        sp_dec,
   output logic        sp_inc,
   output logic        int_ack,
   output logic        busy
);

   localparam logic [3:0] S_BOOT    = 4'd0;
   localparam logic [3:0] S_RUN     = 4'd1;
   localparam logic [3:0] S_DRAIN   = 4'd2;
   localparam logic [3:0] S_PUSH_LO = 4'd3;
   localparam logic [3:0] S_PUSH_HI = 4'd4;
   localparam logic [3:0] S_VEC     = 4'd5;
   localparam logic [3:0] S_POP_HI  = 4'd6;
   localparam logic [3:0] S_POP_LO  = 4'd7;
   localparam logic [3:0] S_RET     = 4'd8;

   localparam logic [1:0] SEL_HOLD = 2'b00;
   localparam logic [1:0] SEL_INC  = 2'b01;
   localparam logic [1:0] SEL_LOAD = 2'b10;
   localparam logic [1:0] SEL_BR   = 2'b11;

   localparam logic [7:0] DRAIN_INIT = 8'(FLUSH_CYCLES - 1);

   logic [3:0]  state;
   logic [3:0]  next_state;
   logic [31:0] ret_pc;
   logic [7:0]  drain_cnt;
   logic        in_push;
   logic        in_pop;
   logic        next_push;
   logic        next_pop;

   assign in_push   = (state == S_PUSH_LO) || (state == S_PUSH_HI);
   assign in_pop    = (state == S_POP_HI) || (state == S_POP_LO);
   assign next_push = (next_state == S_PUSH_LO) || (next_state == S_PUSH_HI);
   assign next_pop  = (next_state == S_POP_HI) || (next_state == S_POP_LO);

   always_comb begin
      next_state = state;
      case (state)
         S_BOOT:    next_state = S_RUN;
         S_RUN: begin
            if (int_req)      next_state = S_DRAIN;
            else if (rti_req) next_state = S_POP_HI;
         end
         S_DRAIN:   if (drain_cnt == 8'd0) next_state = S_PUSH_LO;
         S_PUSH_LO: if (mem_ack) next_state = S_PUSH_HI;
         S_PUSH_HI: if (mem_ack) next_state = S_VEC;
         S_VEC:     next_state = S_RUN;
         S_POP_HI:  if (mem_ack) next_state = S_POP_LO;
         S_POP_LO:  if (mem_ack) next_state = S_RET;
         S_RET:     next_state = S_RUN;
         default:   next_state = S_BOOT;
      endcase
   end

   // pc_sel/pc_load_val are combinational so the PC register sees them in the same cycle.
   always_comb begin
      pc_sel      = SEL_HOLD;
      pc_load_val = 32'd0;
      if (reset) begin
         case (state)
            S_BOOT: begin
               pc_sel      = SEL_LOAD;
               pc_load_val = RESET_VECTOR;
            end
            S_RUN: begin
               if (int_req || rti_req || stall_in) pc_sel = SEL_HOLD;
               else if (branch_taken)              pc_sel = SEL_BR;
               else if (pc_cur < PC_LIMIT)         pc_sel = SEL_INC;
               else                                pc_sel = SEL_HOLD;
            end
            S_VEC: begin
               pc_sel      = SEL_LOAD;
               pc_load_val = INT_VECTOR;
            end
            S_RET: begin
               pc_sel      = SEL_LOAD;
               pc_load_val = ret_pc;
            end
            default: pc_sel = SEL_HOLD;
         endcase
      end
   end

   logic unused_dst;
   assign unused_dst = ^branch_dst;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_BOOT;
         ret_pc    <= 32'd0;
         drain_cnt <= 8'd0;
         flush     <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_wdata <= 16'd0;
         sp_dec    <= 1'b0;
         sp_inc    <= 1'b0;
         int_ack   <= 1'b0;
         busy      <= 1'b1;
      end else begin
         state <= next_state;
         if (state == S_RUN && int_req) begin
            ret_pc    <= pc_cur;
            drain_cnt <= DRAIN_INIT;
         end else if (state == S_DRAIN && drain_cnt != 8'd0) begin
            drain_cnt <= drain_cnt - 8'd1;
         end
         if (state == S_POP_HI && mem_ack) ret_pc[31:16] <= mem_rdata;
         if (state == S_POP_LO && mem_ack) ret_pc[15:0]  <= mem_rdata;

         // Flush trails the decision by one cycle, so it covers the RUN decision plus every DRAIN cycle.
         flush   <= (state == S_RUN && (int_req || rti_req)) || (state == S_DRAIN);
         mem_req <= next_push || next_pop;
         mem_we  <= next_push;
         if (next_state == S_PUSH_LO)      mem_wdata <= ret_pc[15:0];
         else if (next_state == S_PUSH_HI) mem_wdata <= ret_pc[31:16];
         else                              mem_wdata <= 16'd0;
         sp_dec  <= in_push && mem_ack;
         sp_inc  <= in_pop && mem_ack;
         int_ack <= (next_state == S_VEC);
         busy    <= (next_state != S_RUN);
      end
   end

endmodule

// File: tb/tb_pc_flow_sequencer.sv
// tb/tb_pc_flow_sequencer.sv - Self-checking bench: step-queue reference model plus directed scenarios.
module tb_pc_flow_sequencer;

   localparam logic [31:0] RESET_VECTOR = 32'h0000_0020;
   localparam logic [31:0] INT_VECTOR   = 32'h0000_0000;
   localparam logic [31:0] PC_LIMIT     = 32'd1000;
   localparam int          FLUSH_CYCLES = 3;

   localparam int K_DRAIN = 0;
   localparam int K_PUSH  = 1;
   localparam int K_POP   = 2;
   localparam int K_LOAD  = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        int_req = 1'b0;
   logic        rti_req = 1'b0;
   logic        stall_in = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_dst = 32'd0;
   logic [31:0] pc_cur = 32'h20;
   logic        mem_ack = 1'b0;
   logic [15:0] mem_rdata;
   logic [1:0]  pc_sel;
   logic [31:0] pc_load_val;
   logic        flush, mem_req, mem_we, sp_dec, sp_inc, int_ack, busy;
   logic [15:0] mem_wdata;

   pc_flow_sequencer dut (
      .clk(clk), .reset(reset), .int_req(int_req), .rti_req(rti_req),
      .stall_in(stall_in), .branch_taken(branch_taken), .branch_dst(branch_dst),
      .pc_cur(pc_cur), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .pc_sel(pc_sel), .pc_load_val(pc_load_val), .flush(flush),
      .mem_req(mem_req), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .sp_dec(sp_dec), .sp_inc(sp_inc), .int_ack(int_ack), .busy(busy)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   // Stack memory responder with programmable wait states.
   int          ws = 0;
   int          wcnt = 0;
   logic        s_done = 1'b0, s_we = 1'b0, s_req = 1'b0;
   logic [15:0] pop_words [0:3];
   logic [1:0]  pop_idx = 2'd0;
   assign mem_rdata = pop_words[pop_idx];

   always @(negedge clk) begin
      s_done = mem_req && mem_ack;
      s_we   = mem_we;
      s_req  = mem_req;
   end

   always @(posedge clk) begin
      #1;
      if (s_done && !s_we) pop_idx = pop_idx + 2'd1;
      if (!mem_req || !reset) begin
         wcnt    = 0;
         mem_ack = 1'b0;
      end else begin
         if (s_done || !s_req) wcnt = 0;
         else wcnt++;
         mem_ack = (wcnt == ws);
      end
   end

   // Reference model: RUN when the step queue is empty; otherwise the head step defines the outputs.
   typedef struct {
      int          kind;
      logic [31:0] val;
      bit          is_int;
      bit          from_stack;
   } step_t;

   step_t       q[$];
   bit          fl_i = 0, dec_i = 0, inc_i = 0;
   logic [31:0] popped = 32'd0;

   function automatic logic [1:0] run_sel();
      if (int_req || rti_req || stall_in) return 2'b00;
      if (branch_taken) return 2'b11;
      if (pc_cur < PC_LIMIT) return 2'b01;
      return 2'b00;
   endfunction

   always @(negedge clk) begin
      logic [1:0]  e_sel;
      logic [31:0] e_val;
      logic        e_req, e_we, e_iack;
      logic [15:0] e_wd;
      bit          nf, nd, ni;
      if (!reset) begin
         chk("rst_pc_sel", pc_sel, 0);
         chk("rst_pc_load_val", pc_load_val, 0);
         chk("rst_flush", flush, 0);
         chk("rst_mem_req", mem_req, 0);
         chk("rst_mem_we", mem_we, 0);
         chk("rst_mem_wdata", mem_wdata, 0);
         chk("rst_sp_dec", sp_dec, 0);
         chk("rst_sp_inc", sp_inc, 0);
         chk("rst_int_ack", int_ack, 0);
         chk("rst_busy", busy, 1);
         q.delete();
         q.push_back('{K_LOAD, RESET_VECTOR, 1'b0, 1'b0});
         fl_i = 0; dec_i = 0; inc_i = 0;
      end else begin
         e_sel = 2'b00; e_val = 32'd0; e_req = 1'b0; e_we = 1'b0; e_iack = 1'b0; e_wd = 16'd0;
         if (q.size() == 0) begin
            e_sel = run_sel();
         end else begin
            case (q[0].kind)
               K_PUSH: begin e_req = 1'b1; e_we = 1'b1; e_wd = q[0].val[15:0]; end
               K_POP:  begin e_req = 1'b1; e_we = 1'b0; end
               K_LOAD: begin
                  e_sel  = 2'b10;
                  e_val  = q[0].from_stack ? popped : q[0].val;
                  e_iack = q[0].is_int;
               end
               default: e_sel = 2'b00;
            endcase
         end
         chk("m_pc_sel", pc_sel, e_sel);
         if (e_sel == 2'b10) chk("m_pc_load_val", pc_load_val, e_val);
         chk("m_mem_req", mem_req, e_req);
         if (e_req) chk("m_mem_we", mem_we, e_we);
         if (e_req && e_we) chk("m_mem_wdata", mem_wdata, e_wd);
         chk("m_int_ack", int_ack, e_iack);
         chk("m_busy", busy, q.size() != 0);
         chk("m_flush", flush, fl_i);
         chk("m_sp_dec", sp_dec, dec_i);
         chk("m_sp_inc", sp_inc, inc_i);

         nf = 0; nd = 0; ni = 0;
         if (q.size() == 0) begin
            if (int_req) begin
               nf = 1;
               for (int i = 0; i < FLUSH_CYCLES; i++) q.push_back('{K_DRAIN, 32'd0, 1'b0, 1'b0});
               q.push_back('{K_PUSH, {16'd0, pc_cur[15:0]}, 1'b0, 1'b0});
               q.push_back('{K_PUSH, {16'd0, pc_cur[31:16]}, 1'b0, 1'b0});
               q.push_back('{K_LOAD, INT_VECTOR, 1'b1, 1'b0});
            end else if (rti_req) begin
               nf = 1;
               q.push_back('{K_POP, 32'd0, 1'b0, 1'b0});
               q.push_back('{K_POP, 32'd0, 1'b0, 1'b0});
               q.push_back('{K_LOAD, 32'd0, 1'b0, 1'b1});
            end
         end else begin
            case (q[0].kind)
               K_DRAIN: begin nf = 1; void'(q.pop_front()); end
               K_PUSH:  if (mem_ack) begin nd = 1; void'(q.pop_front()); end
               K_POP:   if (mem_ack) begin
                  ni = 1;
                  popped = {popped[15:0], mem_rdata};
                  void'(q.pop_front());
               end
               default: void'(q.pop_front());
            endcase
         end
         fl_i = nf; dec_i = nd; inc_i = ni;
      end
   end

   // Event counters for the directed scenarios.
   int          flush_n, dec_n, inc_n, iack_n, req_n, boot_n;
   logic        first_we;
   logic [31:0] last_load;
   logic [15:0] pushes[$];

   always @(negedge clk) begin
      if (flush) flush_n++;
      if (sp_dec) dec_n++;
      if (sp_inc) inc_n++;
      if (int_ack) iack_n++;
      if (mem_req) begin
         if (req_n == 0) first_we = mem_we;
         req_n++;
      end
      if (pc_sel == 2'b10) begin
         last_load = pc_load_val;
         if (pc_load_val == RESET_VECTOR) boot_n++;
      end
      if (mem_req && mem_ack && mem_we) pushes.push_back(mem_wdata);
   end

   task automatic clear_counts();
      flush_n = 0; dec_n = 0; inc_n = 0; iack_n = 0; req_n = 0; boot_n = 0;
      first_we = 1'bx; last_load = 32'hdead_beef;
      pushes.delete();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
      #2;
   endtask

   task automatic wait_idle(input int limit);
      int n;
      n = 0;
      do begin
         sample();
         n++;
      end while (busy && n < limit);
      chk("idle_timeout", busy, 0);
   endtask

   initial begin
      pop_words[0] = 16'h0001; pop_words[1] = 16'h2345;
      pop_words[2] = 16'h0000; pop_words[3] = 16'h0000;
      clear_counts();
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;

      // Boot load, then sequential fetch
      sample();
      chk("boot_sel", pc_sel, 2'b10);
      chk("boot_val", pc_load_val, 32'h20);
      sample();
      chk("run_inc", pc_sel, 2'b01);

      // Stall beats branch; branch wins once stall drops
      tick(); stall_in = 1; branch_taken = 1; branch_dst = 32'h400;
      sample();
      chk("stall_over_branch", pc_sel, 2'b00);
      tick(); stall_in = 0;
      sample();
      chk("branch_sel", pc_sel, 2'b11);
      tick(); branch_taken = 0;

      // Interrupt entry with two wait states per push
      clear_counts(); pc_cur = 32'h0001_2345; ws = 2; int_req = 1;
      tick(); int_req = 0;
      wait_idle(60);
      chk("int_flush_cycles", flush_n, 4);
      chk("int_sp_dec", dec_n, 2);
      chk("int_push_count", pushes.size(), 2);
      if (pushes.size() == 2) begin
         chk("int_push_lo", pushes[0], 16'h2345);
         chk("int_push_hi", pushes[1], 16'h0001);
      end
      chk("int_ack_count", iack_n, 1);
      chk("int_vec_val", last_load, 32'h0);

      // RTI with zero-wait pops
      tick(); clear_counts(); pc_cur = 32'h100; ws = 0; pop_idx = 2'd0;
      tick(); rti_req = 1;
      tick(); rti_req = 0;
      wait_idle(60);
      chk("rti_ret_val", last_load, 32'h0001_2345);
      chk("rti_sp_inc", inc_n, 2);
      chk("rti_sp_dec", dec_n, 0);

      // int_req and rti_req together: interrupt path, no pops
      tick(); clear_counts(); pc_cur = 32'h0ABC_DEF0; ws = 1; int_req = 1; rti_req = 1;
      tick(); int_req = 0; rti_req = 0;
      wait_idle(60);
      chk("both_first_we", first_we, 1);
      chk("both_sp_inc", inc_n, 0);
      chk("both_sp_dec", dec_n, 2);
      if (pushes.size() == 2) chk("both_push_lo", pushes[0], 16'hDEF0);
      else chk("both_push_count", pushes.size(), 2);

      // Reset during PUSH_HI
      tick(); clear_counts(); pc_cur = 32'h5555_AAAA; ws = 3; int_req = 1;
      tick(); int_req = 0;
      begin
         int n;
         n = 0;
         do begin
            sample();
            n++;
         end while (!(mem_req && mem_wdata == 16'h5555) && n < 40);
         chk("push_hi_timeout", mem_req && mem_wdata == 16'h5555, 1);
      end
      #1 reset = 1'b0;
      #1;
      chk("arst_pc_sel", pc_sel, 0);
      chk("arst_mem_req", mem_req, 0);
      chk("arst_mem_wdata", mem_wdata, 0);
      chk("arst_busy", busy, 1);
      chk("arst_flush", flush, 0);
      repeat (2) @(posedge clk);
      tick(); clear_counts(); reset = 1'b1;
      repeat (6) sample();
      chk("arst_no_req", req_n, 0);
      chk("arst_reboot", boot_n, 1);
      chk("arst_no_push", pushes.size(), 0);

      // PC limit boundary
      tick(); pc_cur = 32'd1000;
      for (int i = 0; i < 3; i++) begin
         sample();
         chk("limit_hold", pc_sel, 2'b00);
      end
      tick(); pc_cur = 32'd999;
      sample();
      chk("below_limit_inc", pc_sel, 2'b01);

      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pc_flow_sequencer.md
Name: pc_flow_sequencer

Overview:
- Sequences every Program Counter update: reset vector, sequential fetch, stall hold, taken branch, interrupt entry and RTI return.
- Interrupt entry drains the pipeline, then pushes the 32-bit return PC onto the stack as two 16-bit words over a req/ack memory handshake, then loads the interrupt vector.
- RTI pops both halves and reloads the PC.
- Sits between the hazard unit/execute stage and the PC register.
- It is the sole driver of pc_sel, pc_load_val and the stack-memory port.

Parameters:
- RESET_VECTOR, 32'h0000_0020: PC value loaded after reset.
- INT_VECTOR, 32'h0000_0000: PC value loaded on interrupt entry.
- PC_LIMIT, 1000: sequential increment is suppressed when pc_cur >= PC_LIMIT.
- FLUSH_CYCLES, 3: pipeline drain cycles before the interrupt push.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- int_req  in  1  level interrupt request.
- rti_req  in  1  one-cycle pulse: RTI decoded in execute.
- stall_in  in  1  hazard-unit stall.
- branch_taken  in  1  taken branch/jump this cycle.
- branch_dst  in  32  branch target.
- pc_cur  in  32  current PC register value.
- mem_ack  in  1  stack memory completed the current access.
- mem_rdata  in  16  stack read data.
- pc_sel  out  2  00 = hold, 01 = increment, 10 = load pc_load_val, 11 = load branch_dst.
- pc_load_val  out  32  value to load when pc_sel = 10.
- flush  out  1  squash the fetch/decode stages.
- mem_req  out  1  stack access request.
- mem_we  out  1  1 = push (write), 0 = pop (read).
- mem_wdata  out  16  push data.
- sp_dec  out  1  pulse: decrement SP, one per completed push.
- sp_inc  out  1  pulse: increment SP, one per completed pop.
- int_ack  out  1  one-cycle pulse when the INT_VECTOR load is issued.
- busy  out  1  high in any state other than RUN.

Behaviour:
- Reset is asynchronous and active-low. While reset = 0:
  - state = BOOT;
  - pc_sel = 00, pc_load_val = 0;
  - flush, mem_req, mem_we, sp_dec, sp_inc, int_ack = 0; mem_wdata = 0;
  - busy = 1.
  - Asserting reset mid-sequence aborts it immediately; nothing is pushed or popped afterwards.
- BOOT (first cycle after release): pc_sel = 10, pc_load_val = RESET_VECTOR, then go to RUN.
- RUN, priority from highest to lowest:
  - int_req: capture ret_pc = pc_cur; flush = 1; pc_sel = 00; load the drain counter with FLUSH_CYCLES-1; go to DRAIN.
  - rti_req: flush = 1; pc_sel = 00; go to POP_HI.
  - stall_in: pc_sel = 00.
  - branch_taken: pc_sel = 11.
  - pc_cur < PC_LIMIT: pc_sel = 01.
  - otherwise: pc_sel = 00.
  - int_req wins over a simultaneous rti_req, stall or branch. The rti_req is dropped; the pipeline re-executes the RTI after the interrupt returns.
- DRAIN:
  - flush = 1, pc_sel = 00.
  - The counter decrements each cycle; at 0, go to PUSH_LO.
  - Total drain = FLUSH_CYCLES cycles. FLUSH_CYCLES = 1 means a single DRAIN cycle.
- PUSH_LO:
  - mem_req = 1, mem_we = 1, mem_wdata = ret_pc[15:0], held stable until mem_ack.
  - On the ack cycle: sp_dec = 1, go to PUSH_HI.
  - mem_ack arriving in the same cycle as mem_req is legal (zero wait states).
- PUSH_HI: same handshake with mem_wdata = ret_pc[31:16]. On ack: sp_dec = 1, go to VEC.
- VEC:
  - pc_sel = 10, pc_load_val = INT_VECTOR, int_ack = 1, go to RUN.
  - int_req must have been deasserted by the source by this point.
  - If int_req is still high on return to RUN, a new entry begins; nested interrupts are allowed.
- POP_HI:
  - mem_req = 1, mem_we = 0.
  - On ack: latch ret_pc[31:16] = mem_rdata, sp_inc = 1, go to POP_LO.
- POP_LO: same handshake; latch ret_pc[15:0] on ack, sp_inc = 1, go to RET.
- RET: pc_sel = 10, pc_load_val = ret_pc, go to RUN.
- During any non-RUN state:
  - stall_in, branch_taken and rti_req are ignored.
  - int_req is ignored until RUN; there is no preemption of an ongoing push or pop.
- Output timing:
  - All outputs are registered except pc_sel and pc_load_val.
  - pc_sel and pc_load_val are combinational from state and inputs, and must settle before the PC register's clock edge.
- PC increment arithmetic is the PC register's job; the sequencer only compares pc_cur against PC_LIMIT (unsigned, 32-bit).

Test Plan:
- Reset release → the cycle after reset rises: pc_sel = 10, pc_load_val = 32'h20. Next cycle: pc_sel = 01 (pc_cur = 32'h20 < 1000).
- RUN with stall_in = 1 and branch_taken = 1 together → pc_sel = 00. Drop stall → pc_sel = 11 while branch_taken is held.
- int_req at pc_cur = 32'h0001_2345, FLUSH_CYCLES = 3, mem_ack after 2 wait states →
  - flush high for 4 cycles (RUN cycle + 3 DRAIN);
  - pushes 16'h2345 then 16'h0001;
  - sp_dec pulses exactly twice;
  - then pc_sel = 10 with pc_load_val = 0 and a one-cycle int_ack.
- rti_req with pops returning 16'h0001 then 16'h2345 (zero-wait acks) → pc_sel = 10, pc_load_val = 32'h0001_2345; sp_inc pulses twice.
- int_req and rti_req in the same cycle → the interrupt path is taken, no pop occurs, mem_we = 1 on the first access.
- Reset asserted during PUSH_HI → all outputs go to their reset values immediately; no further mem_req after release; the BOOT sequence repeats.
- pc_cur = 1000 in RUN, no other event → pc_sel = 00 held.
